// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//
// This is a single-clock FIFO with status flags. It provides:
//   - programmable almost-full and almost-empty thresholds,
//   - an occupancy count,
//   - sticky overflow and underflow error flags,
//   - a read mode chosen at elaboration: registered read or first-word-fall-through.
//
// The request interface matches the asynchronous FIFO, so this FIFO can replace
// it when producer and consumer share one clock.
//
// Parameters
//   DATA_WIDTH : width of w_data / r_data
//   ADDR_WIDTH : log2 of the depth (DEPTH = 2**ADDR_WIDTH)
//   AF_LEVEL   : w_almost_full is high when count >= AF_LEVEL   (1..DEPTH)
//   AE_LEVEL   : r_almost_empty is high when count <= AE_LEVEL  (0..DEPTH-1)
//   FWFT       : 0 = registered read, 1 = first-word-fall-through
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   w_req, w_data   : write request and write data
//   w_full          : FIFO holds DEPTH entries
//   w_almost_full   : count >= AF_LEVEL
//   r_req           : read request (pop)
//   r_data, r_valid : read data and its qualifier (timing depends on FWFT)
//   r_empty         : FIFO holds no entries
//   r_almost_empty  : count <= AE_LEVEL
//   count           : current occupancy, 0..DEPTH
//   err_clr         : clears the sticky error flags
//   overflow        : sticky, a write was attempted while full
//   underflow       : sticky, a read was attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_req,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_full,
  output logic                  w_almost_full,
  input  logic                  r_req,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  r_empty,
  output logic                  r_almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_en, rd_en;

  // All status flags are decoded from the registered count only, so no
  // combinational path runs from the request inputs to any flag.
  assign w_full         = (count_q == DEPTH_C);
  assign r_empty        = (count_q == '0);
  assign w_almost_full  = (count_q >= AF_C);
  assign r_almost_empty = (count_q <= AE_C);
  assign count          = count_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

  // The flags are sampled before the edge. When the FIFO is full, a read is
  // still accepted. When it is empty, a write is still accepted. Neither
  // case bypasses the storage array.
  assign wr_en = w_req & ~w_full;
  assign rd_en = r_req & ~r_empty;

  // NOTE: every output of always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    // The error flags are sticky. An error in the same cycle as err_clr wins.
    overflow_d  = (w_req & w_full)  | (overflow_q  & ~err_clr);
    underflow_d = (r_req & r_empty) | (underflow_q & ~err_clr);

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset. Clearing the pointers and count already discards its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= w_data;
  end

  if (FWFT != 0) begin : g_fwft
    // The head word is shown combinationally. r_req pops the word on display.
    assign r_data  = mem_q[rd_ptr_q];
    assign r_valid = ~r_empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_valid_q;

    // r_data holds its last value between reads. r_valid pulses for one
    // cycle after each accepted read.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= rd_en;
        if (rd_en) r_data_q <= mem_q[rd_ptr_q];
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end

endmodule
